// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with KMP progress tracking,
// runtime overlap mode, input gating, synchronous clear and a saturating
// match counter.
module seq_detector_param #(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11001,
  parameter int unsigned          CNT_W   = 8,
  localparam int unsigned         PW      = $clog2(PAT_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic             overlap_i,
  output logic             out_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [PW-1:0]    progress_o
);

  logic [PW-1:0]    progress_q, progress_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    nxt_c;
  logic             match_c;

  // Longest proper prefix of PATTERN (length < PAT_LEN) that is a suffix of
  // (first p pattern bits followed by b). In the completing case this is the
  // longest proper border of PATTERN, which is what overlap mode resumes from.
  function automatic logic [PW-1:0] kmp_next(input logic [PW-1:0] p, input logic b);
    int unsigned pv;
    int unsigned best;
    int unsigned si;
    logic        ok;
    logic        sb;
    pv   = 32'(p);
    best = 0;
    for (int unsigned k = 1; k < PAT_LEN; k++) begin
      if (k <= pv + 1) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < k; j++) begin
          si = pv + 1 - k + j;
          sb = (si == pv) ? b : PATTERN[PW'(PAT_LEN - 1 - si)];
          if (sb != PATTERN[PW'(PAT_LEN - 1 - j)]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return PW'(best);
  endfunction

  // Transition and match decode, purely combinational from progress and the input bit
  always_comb begin
    nxt_c   = kmp_next(progress_q, in_i);
    match_c = (progress_q == PW'(PAT_LEN - 1)) && (in_i == PATTERN[0]);
  end

  // Next-state: clear beats a valid bit, which beats idle
  always_comb begin
    progress_d = progress_q;
    out_d      = 1'b0;
    cnt_d      = cnt_q;
    if (clear_i) begin
      progress_d = '0;
      cnt_d      = '0;
    end else if (in_valid_i) begin
      if (match_c) begin
        out_d      = 1'b1;
        progress_d = overlap_i ? nxt_c : '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        progress_d = nxt_c;
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      progress_q <= '0;
      out_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      progress_q <= progress_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_o       = out_q;
  assign match_cnt_o = cnt_q;
  assign progress_o  = progress_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: stream-history reference model checked every
// cycle on two instances (default counter and a 2-bit saturating counter),
// plus hand-computed expectations per directed scenario.
module tb_seq_detector_param;

  localparam int unsigned PAT_LEN = 5;
  localparam logic [4:0]  PAT     = 5'b11001;
  localparam int unsigned PW      = 3;

  logic clk;
  logic rst_n;
  logic clear_s, in_valid_s, in_s, overlap_s;

  logic          out_a, out_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;
  logic [PW-1:0] prog_a, prog_b;

  seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_s), .in_valid_i(in_valid_s),
    .in_i(in_s), .overlap_i(overlap_s), .out_o(out_a), .match_cnt_o(cnt_a),
    .progress_o(prog_a));

  seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_s), .in_valid_i(in_valid_s),
    .in_i(in_s), .overlap_i(overlap_s), .out_o(out_b), .match_cnt_o(cnt_b),
    .progress_o(prog_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: keeps the accepted bit history (bit 0 = newest)
  logic [63:0] hist;
  int          hlen;
  logic        m_out;
  int          m_prog;
  int          m_cnt_a;
  int          m_cnt_b;

  // Longest k <= maxk where the newest k history bits spell the first k pattern bits
  function automatic int pref_len(input logic [63:0] h, input int hl, input int maxk);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k <= maxk; k++) begin
      if (k <= hl) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (h[6'(k - 1 - j)] != PAT[3'(PAT_LEN - 1 - j)]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Model update on each accepted event
  always @(posedge clk or negedge rst_n) begin : model
    logic [63:0] nh;
    int          nl;
    if (!rst_n) begin
      hist <= '0; hlen <= 0; m_out <= 1'b0; m_prog <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else if (clear_s) begin
      hlen <= 0; m_out <= 1'b0; m_prog <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
    end else if (!in_valid_s) begin
      m_out <= 1'b0;
    end else begin
      nh = {hist[62:0], in_s};
      nl = (hlen < 64) ? hlen + 1 : 64;
      if (pref_len(nh, nl, PAT_LEN) == PAT_LEN) begin
        m_out   <= 1'b1;
        m_cnt_a <= (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
        m_cnt_b <= (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
        if (!overlap_s) nl = 0;
      end else begin
        m_out <= 1'b0;
      end
      hist   <= nh;
      hlen   <= nl;
      m_prog <= pref_len(nh, nl, PAT_LEN - 1);
    end
  end

  int          total;
  int          passed;
  int          bits_sent;
  logic [31:0] mask;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // One cycle: check both DUTs against the model, log pulses, then drive inputs
  task automatic tick(input logic c, input logic v, input logic b);
    @(negedge clk);
    #1;
    cmp("out_a",  32'(out_a),  32'(m_out));
    cmp("prog_a", 32'(prog_a), 32'(m_prog));
    cmp("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
    cmp("out_b",  32'(out_b),  32'(m_out));
    cmp("prog_b", 32'(prog_b), 32'(m_prog));
    cmp("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
    if (out_a && bits_sent < 32) mask[5'(bits_sent)] = 1'b1;
    clear_s    = c;
    in_valid_s = v;
    in_s       = b;
    if (rst_n && v && !c) bits_sent++;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b1, bits[5'(i)]);
  endtask

  task automatic start_test();
    tick(1'b1, 1'b0, 1'b0);
    bits_sent = 0;
    mask      = '0;
  endtask

  task automatic end_checks(input string tag, input logic [31:0] emask,
                            input logic [31:0] ecnt, input logic [31:0] eprog);
    cmp({tag, "_pulses"}, mask, emask);
    cmp({tag, "_cnt"}, 32'(cnt_a), ecnt);
    cmp({tag, "_prog"}, 32'(prog_a), eprog);
  endtask

  int exp6[5] = '{1, 2, 3, 3, 3};

  initial begin
    total = 0; passed = 0; bits_sent = 0; mask = '0;
    rst_n = 1'b0; clear_s = 1'b0; in_valid_s = 1'b0; in_s = 1'b0; overlap_s = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    cmp("rst_out", 32'(out_a), 32'd0);
    cmp("rst_cnt", 32'(cnt_a), 32'd0);
    cmp("rst_prog", 32'(prog_a), 32'd0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Overlapping detection
    overlap_s = 1'b1;
    start_test();
    send(32'b110011001, 9);
    tick(1'b0, 1'b0, 1'b0);
    end_checks("t1", 32'h220, 32'd2, 32'd1);

    // Non-overlapping detection
    overlap_s = 1'b0;
    start_test();
    send(32'b110011001, 9);
    tick(1'b0, 1'b0, 1'b0);
    end_checks("t2", 32'h20, 32'd1, 32'd1);

    // KMP fallback on the extra 1
    overlap_s = 1'b1;
    start_test();
    send(32'b11001110011, 11);
    tick(1'b0, 1'b0, 1'b0);
    end_checks("t3", 32'h420, 32'd2, 32'd2);

    // in_valid gap inside a pattern
    start_test();
    send(32'b110, 3);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    send(32'b01, 2);
    tick(1'b0, 1'b0, 1'b0);
    end_checks("t4", 32'h20, 32'd1, 32'd1);

    // Asynchronous reset between edges, then partial pattern must not match
    bits_sent = 0;
    mask      = '0;
    send(32'b110, 3);
    tick(1'b0, 1'b0, 1'b0);
    cmp("t5_pre_prog", 32'(prog_a), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    cmp("t5_rst_out", 32'(out_a), 32'd0);
    cmp("t5_rst_prog", 32'(prog_a), 32'd0);
    cmp("t5_rst_cnt", 32'(cnt_a), 32'd0);
    cmp("t5_rst_cnt_b", 32'(cnt_b), 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b1;
    bits_sent = 0;
    mask      = '0;
    send(32'b01, 2);
    tick(1'b0, 1'b0, 1'b0);
    end_checks("t5", 32'h0, 32'd0, 32'd1);

    // Counter saturation on the 2-bit instance, then clear wins over a valid bit
    overlap_s = 1'b0;
    start_test();
    for (int i = 0; i < 5; i++) begin
      send(32'b11001, 5);
      tick(1'b0, 1'b0, 1'b0);
      cmp("t6_cnt_b", 32'(cnt_b), 32'(exp6[i]));
      cmp("t6_cnt_a", 32'(cnt_a), 32'(i + 1));
    end
    cmp("t6_pulses", mask, 32'h02108420);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    cmp("t6_clr_cnt_b", 32'(cnt_b), 32'd0);
    cmp("t6_clr_cnt_a", 32'(cnt_a), 32'd0);
    cmp("t6_clr_prog", 32'(prog_b), 32'd0);
    cmp("t6_clr_out", 32'(out_b), 32'd0);
    tick(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
